// File: rtl/gx_wb_pkg.sv
// gx_wb_pkg: shared types and AXI constants for the GX write arbiter.
// Holds the FSM state enum, AXI size/burst codes and BRESP codes.
package gx_wb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    RESP
  } state_t;

  localparam logic [2:0] SIZE_16B   = 3'b100;
  localparam logic [1:0] BURST_INCR = 2'b01;

  localparam logic [1:0] OKAY        = 2'd0;
  localparam logic [1:0] SLVERR      = 2'd2;
  localparam logic [1:0] DECERR      = 2'd3;
  localparam logic [1:0] TIMEOUT_ERR = DECERR;

  function automatic logic [7:0] burst_len(input logic size);
    return {7'd0, size};
  endfunction

endpackage

// File: rtl/gx_wb_rr_pick.sv
// gx_wb_rr_pick: combinational 2-way round-robin picker.
// Ports: req[1:0], last_grant in; grant (winner index), any out.
module gx_wb_rr_pick
  import gx_wb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       any
);

  always_comb begin
    any   = |req;
    grant = 1'b0;
    case (req)
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/gx_wb_arbiter.sv
// gx_wb_arbiter: shares one AXI write master between two GX writers.
// Ports: req/addr/size/data in, next/done/err out per requester;
// AXI AW/W/B master channel (*_a). Optional B watchdog when
// GX_WB_ARB_TIMEOUT_EN is defined (limit = TIMEOUT cycles).
module gx_wb_arbiter
  import gx_wb_pkg::*;
#(
  parameter int ADDR_W  = 49,
  parameter int DATA_W  = 128,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              size0,
  input  logic              size1,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  output logic              next0,
  output logic              next1,
  output logic              done0,
  output logic              done1,
  output logic [1:0]        err0,
  output logic [1:0]        err1,
  output logic [ADDR_W-1:0] awaddr_a,
  output logic [7:0]        awlen_a,
  output logic [2:0]        awsize_a,
  output logic [1:0]        awburst_a,
  output logic              awvalid_a,
  input  logic              awready_a,
  output logic [DATA_W-1:0] wdata_a,
  output logic [15:0]       wstrb_a,
  output logic              wlast_a,
  output logic              wvalid_a,
  input  logic              wready_a,
  input  logic [1:0]        bresp_a,
  input  logic              bvalid_a,
  output logic              bready_a
);

  if (TIMEOUT < 2) begin : g_bad_cfg
    $error("gx_wb_arbiter: TIMEOUT must be >= 2");
  end

  state_t     state;
  state_t     state_n;
  logic       owner;
  logic       last_grant;
  logic       beat;
  logic       grant;
  logic       any;
  logic       err_wr;
  logic [1:0] err_code;

  assign awsize_a  = SIZE_16B;
  assign awburst_a = BURST_INCR;
  assign wstrb_a   = 16'hFFFF;

  gx_wb_rr_pick u_pick (
    .req        ({req1, req0}),
    .last_grant (last_grant),
    .grant      (grant),
    .any        (any)
  );

`ifdef GX_WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0] cnt;
  logic          to_hit;

  assign to_hit = (cnt == CW'(TIMEOUT - 1));

  // Zero everywhere outside RESP, so it is clear on entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (state != RESP) begin
      cnt <= '0;
    end else if (!bvalid_a && !to_hit) begin
      cnt <= cnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    awvalid_a = 1'b0;
    wvalid_a  = 1'b0;
    wlast_a   = 1'b0;
    wdata_a   = '0;
    bready_a  = 1'b0;
    next0     = 1'b0;
    next1     = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    err_wr    = 1'b0;
    err_code  = bresp_a;
    unique case (state)
      IDLE: begin
        if (any) state_n = ADDR;
      end
      ADDR: begin
        awvalid_a = 1'b1;
        if (awready_a) state_n = DATA;
      end
      DATA: begin
        wvalid_a = 1'b1;
        wdata_a  = owner ? data1 : data0;
        wlast_a  = (beat == awlen_a[0]);
        if (wready_a) begin
          next0 = ~owner;
          next1 = owner;
          if (wlast_a) state_n = RESP;
        end
      end
      RESP: begin
        bready_a = 1'b1;
        if (bvalid_a) begin
          err_wr = 1'b1;
        end
`ifdef GX_WB_ARB_TIMEOUT_EN
        else if (to_hit) begin
          err_wr   = 1'b1;
          err_code = TIMEOUT_ERR;
        end
`endif
        if (err_wr) begin
          done0   = ~owner;
          done1   = owner;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner      <= 1'b0;
      last_grant <= 1'b1;
      awaddr_a   <= '0;
      awlen_a    <= '0;
      beat       <= 1'b0;
      err0       <= OKAY;
      err1       <= OKAY;
    end else begin
      if (state == IDLE && any) begin
        owner    <= grant;
        awaddr_a <= grant ? addr1 : addr0;
        awlen_a  <= burst_len(grant ? size1 : size0);
      end
      if (state == ADDR && awready_a) begin
        beat <= 1'b0;
      end
      if (state == DATA && wready_a && !wlast_a) begin
        beat <= 1'b1;
      end
      if (err_wr) begin
        last_grant <= owner;
        if (owner) err1 <= err_code;
        else       err0 <= err_code;
      end
    end
  end

endmodule

// File: tb/tb_gx_wb_arbiter.sv
// tb_gx_wb_arbiter: table-driven check of gx_wb_arbiter.
// Drives a directed AXI slave per transaction record.
module tb_gx_wb_arbiter;

  localparam int AW = 49;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1;
  logic [AW-1:0] addr0, addr1;
  logic          size0, size1;
  logic [DW-1:0] data0, data1;
  logic          next0, next1;
  logic          done0, done1;
  logic [1:0]    err0, err1;
  logic [AW-1:0] awaddr_a;
  logic [7:0]    awlen_a;
  logic [2:0]    awsize_a;
  logic [1:0]    awburst_a;
  logic          awvalid_a;
  logic          awready_a;
  logic [DW-1:0] wdata_a;
  logic [15:0]   wstrb_a;
  logic          wlast_a;
  logic          wvalid_a;
  logic          wready_a;
  logic [1:0]    bresp_a;
  logic          bvalid_a;
  logic          bready_a;

  int total = 0;
  int bad   = 0;
  int b0, b1;

  always #5 clk = ~clk;

  gx_wb_arbiter #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .req1      (req1),
    .addr0     (addr0),
    .addr1     (addr1),
    .size0     (size0),
    .size1     (size1),
    .data0     (data0),
    .data1     (data1),
    .next0     (next0),
    .next1     (next1),
    .done0     (done0),
    .done1     (done1),
    .err0      (err0),
    .err1      (err1),
    .awaddr_a  (awaddr_a),
    .awlen_a   (awlen_a),
    .awsize_a  (awsize_a),
    .awburst_a (awburst_a),
    .awvalid_a (awvalid_a),
    .awready_a (awready_a),
    .wdata_a   (wdata_a),
    .wstrb_a   (wstrb_a),
    .wlast_a   (wlast_a),
    .wvalid_a  (wvalid_a),
    .wready_a  (wready_a),
    .bresp_a   (bresp_a),
    .bvalid_a  (bvalid_a),
    .bready_a  (bready_a)
  );

  typedef struct {
    logic          r0, r1;
    logic          s0, s1;
    logic [AW-1:0] a0, a1;
    int            aws, ws;
    logic [1:0]    br;
    logic          own;
    logic [AW-1:0] addr;
    logic          len;
    logic [1:0]    e0, e1;
    logic          to;
  } vec_t;

  vec_t tbl[10];
  vec_t v;

  function automatic vec_t mk(
    logic r0, logic r1, logic s0, logic s1,
    logic [AW-1:0] a0, logic [AW-1:0] a1,
    int aws, int ws, logic [1:0] br,
    logic own, logic [AW-1:0] addr, logic len,
    logic [1:0] e0, logic [1:0] e1
  );
    vec_t t;
    t.r0 = r0; t.r1 = r1; t.s0 = s0; t.s1 = s1;
    t.a0 = a0; t.a1 = a1; t.aws = aws; t.ws = ws;
    t.br = br; t.own = own; t.addr = addr;
    t.len = len; t.e0 = e0; t.e1 = e1; t.to = 1'b0;
    return t;
  endfunction

  function automatic logic [DW-1:0] dv(int r, int b);
    return {32'h0, 32'(r), 32'(b), 32'hCAFE0000};
  endfunction

  task automatic chk(string name, logic [DW-1:0] act,
                     logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic do_txn(input vec_t t);
    int n;
    int nb;
    nb = t.len ? 2 : 1;
    req0 = t.r0; req1 = t.r1;
    size0 = t.s0; size1 = t.s1;
    addr0 = t.a0; addr1 = t.a1;
    awready_a = 0; wready_a = 0;
    bvalid_a = 0; bresp_a = 0;
    b0 = 0; b1 = 0;
    data0 = dv(0, 0); data1 = dv(1, 0);
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (!awvalid_a && n < 8);
    chk("aw_wait", awvalid_a, 1);
    chk("awaddr", awaddr_a, t.addr);
    chk("awlen", awlen_a, {7'd0, t.len});
    chk("w_before_aw", wvalid_a, 0);
    repeat (t.aws) begin
      @(negedge clk); #1;
      chk("aw_hold", awvalid_a, 1);
      chk("aw_stable", awaddr_a, t.addr);
      chk("aw_stall_nw", wvalid_a, 0);
    end
    awready_a = 1;
    @(negedge clk);
    awready_a = 0;
    for (int i = 0; i < nb; i++) begin
      if (i == 0) begin
        repeat (t.ws) begin
          #1;
          chk("w_stall_valid", wvalid_a, 1);
          chk("w_stall_data", wdata_a, dv(t.own, 0));
          chk("w_stall_next", next0 | next1, 0);
          @(negedge clk);
        end
      end
      wready_a = 1;
      #1;
      chk("wvalid", wvalid_a, 1);
      chk("wdata", wdata_a, dv(t.own, i));
      chk("wlast", wlast_a, (i == nb - 1));
      chk("next_own", t.own ? next1 : next0, 1);
      chk("next_other", t.own ? next0 : next1, 0);
      @(negedge clk);
      wready_a = 0;
      if (t.own) b1++;
      else       b0++;
      data0 = dv(0, b0);
      data1 = dv(1, b1);
    end
    if (t.to) begin
      n = 1;
      #1;
      while (!(done0 | done1) && n < 64) begin
        @(negedge clk); #1; n++;
      end
      chk("to_cycles", n, 16);
    end else begin
      #1;
      chk("bready", bready_a, 1);
      chk("w_off_resp", wvalid_a, 0);
      chk("done_early", done0 | done1, 0);
      bvalid_a = 1;
      bresp_a = t.br;
    end
    #1;
    chk("done_own", t.own ? done1 : done0, 1);
    chk("done_other", t.own ? done0 : done1, 0);
    @(negedge clk);
    bvalid_a = 0;
    bresp_a = 0;
    req0 = 0;
    req1 = 0;
    #1;
    chk("err0", err0, t.e0);
    chk("err1", err1, t.e1);
    chk("idle_aw", awvalid_a, 0);
    chk("idle_b", bready_a, 0);
  endtask

  task automatic chk_reset_outs(string tag);
    chk({tag, "_awvalid"}, awvalid_a, 0);
    chk({tag, "_wvalid"}, wvalid_a, 0);
    chk({tag, "_wlast"}, wlast_a, 0);
    chk({tag, "_bready"}, bready_a, 0);
    chk({tag, "_next"}, {next1, next0}, 0);
    chk({tag, "_done"}, {done1, done0}, 0);
    chk({tag, "_err"}, {err1, err0}, 0);
    chk({tag, "_awaddr"}, awaddr_a, 0);
    chk({tag, "_awlen"}, awlen_a, 0);
    chk({tag, "_awsize"}, awsize_a, 3'b100);
    chk({tag, "_awburst"}, awburst_a, 2'b01);
    chk({tag, "_wstrb"}, wstrb_a, 16'hFFFF);
  endtask

  initial begin
    tbl[0] = mk(1, 0, 0, 0, 'h1000, 'h0, 0, 0, 0,
                0, 'h1000, 0, 0, 0);
    tbl[1] = mk(1, 1, 0, 0, 'h2000, 'h3000, 0, 0, 0,
                1, 'h3000, 0, 0, 0);
    tbl[2] = mk(1, 1, 0, 0, 'h2000, 'h3000, 0, 0, 0,
                0, 'h2000, 0, 0, 0);
    tbl[3] = mk(1, 1, 0, 0, 'h2000, 'h3000, 0, 0, 0,
                1, 'h3000, 0, 0, 0);
    tbl[4] = mk(0, 1, 0, 1, 'h0, 'h4000, 0, 3, 0,
                1, 'h4000, 1, 0, 0);
    tbl[5] = mk(1, 0, 0, 0, 'h5000, 'h0, 5, 0, 0,
                0, 'h5000, 0, 0, 0);
    tbl[6] = mk(1, 0, 0, 0, 'h5100, 'h0, 0, 0, 2,
                0, 'h5100, 0, 2, 0);
    tbl[7] = mk(0, 1, 0, 0, 'h0, 'h6000, 0, 0, 3,
                1, 'h6000, 0, 2, 3);
    tbl[8] = mk(1, 0, 0, 0, 'h7000, 'h0, 0, 0, 0,
                0, 'h7000, 0, 0, 3);
    tbl[9] = mk(1, 1, 1, 1, 'h8000, 'h9000, 1, 1, 2,
                1, 'h9000, 1, 0, 2);

    reset = 1;
    req0 = 0; req1 = 0; size0 = 0; size1 = 0;
    addr0 = '0; addr1 = '0;
    data0 = '0; data1 = '0;
    awready_a = 0; wready_a = 0;
    bvalid_a = 0; bresp_a = 0;
    repeat (2) @(negedge clk);
    #1;
    chk_reset_outs("rst");
    @(negedge clk);
    reset = 0;

    for (int k = 0; k < 10; k++) begin
      do_txn(tbl[k]);
    end

`ifdef GX_WB_ARB_TIMEOUT_EN
    v = mk(1, 0, 0, 0, 'hA000, 'h0, 0, 0, 0,
           0, 'hA000, 0, 3, 2);
    v.to = 1'b1;
    do_txn(v);
`endif

    req0 = 1; size0 = 1; addr0 = 'hB000;
    begin : mid_reset
      int n;
      n = 0;
      do begin
        @(negedge clk); #1; n++;
      end while (!awvalid_a && n < 8);
      chk("mr_aw_wait", awvalid_a, 1);
      awready_a = 1;
      @(negedge clk);
      awready_a = 0;
      #1;
      chk("mr_in_data", wvalid_a, 1);
      reset = 1;
      req0 = 0;
      @(negedge clk);
      #1;
      chk_reset_outs("mr");
      reset = 0;
    end

    v = mk(1, 1, 0, 0, 'hC000, 'hD000, 0, 0, 0,
           0, 'hC000, 0, 0, 0);
    do_txn(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gx_wb_arbiter.md
Name: gx_wb_arbiter

Overview:
- Two-requester arbiter and sequencer that shares one 128-bit AXI write master port.
- Requester 0 is the write-gather pipe flush path (1- or 2-beat bursts). Requester 1 is a second GX writer, e.g. EFB copy-out.
- Grants round-robin, locks the port for a whole AW/W/B transaction, and returns beat-accept, done and response status to the owning requester.
- Sits between the CP write-gather logic and the AXI interconnect, replacing a dedicated per-requester master.

Parameters:
- ADDR_W, 49, AXI address width.
- DATA_W, 128, AXI data width (one beat = 16 bytes).
- TIMEOUT, 1024, B-response watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req0 / req1  in  1  transaction request; held until done.
- addr0 / addr1  in  ADDR_W  burst start address.
- size0 / size1  in  1  0 = 1 beat, 1 = 2 beats.
- data0 / data1  in  DATA_W  current beat data; advances after next.
- next0 / next1  out  1  one-cycle pulse: current beat accepted.
- done0 / done1  out  1  one-cycle pulse: B response received.
- err0 / err1  out  2  bresp of the requester's last completed transaction.
- awaddr_a  out  ADDR_W  AXI write address.
- awlen_a  out  8  AXI burst length.
- awsize_a  out  3  AXI beat size.
- awburst_a  out  2  AXI burst type.
- awvalid_a  out  1  AXI AW valid.
- awready_a  in  1  AXI AW ready.
- wdata_a  out  DATA_W  AXI write data.
- wstrb_a  out  16  AXI write strobes.
- wlast_a  out  1  AXI last beat.
- wvalid_a  out  1  AXI W valid.
- wready_a  in  1  AXI W ready.
- bresp_a  in  2  AXI write response.
- bvalid_a  in  1  AXI B valid.
- bready_a  out  1  AXI B ready.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE, owner = 0, last_grant = 1, so req0 wins first.
  - All valid/ready/pulse outputs = 0; err0 = err1 = 0.
  - awaddr_a = 0, awlen_a = 0.
- Constant outputs: awsize_a = 3'b100; awburst_a = 2'b01 (INCR); wstrb_a = 16'hFFFF.
- IDLE:
  - If exactly one req is high, grant it. If both are high, grant the requester that is not last_grant.
  - Latch owner, awaddr_a = addr[owner], awlen_a = {7'd0, size[owner]}.
  - Move to ADDR; awvalid_a rises the cycle after the grant.
- ADDR:
  - awvalid_a = 1 until awvalid_a & awready_a.
  - Then go to DATA with beat = 0.
  - No W beat is issued before the AW handshake.
- DATA:
  - wvalid_a = 1; wdata_a = data[owner], muxed combinationally.
  - wlast_a = (beat == awlen_a[0]).
  - On wready_a: next[owner] pulses in the same cycle. If wlast_a, go to RESP; else beat = beat + 1.
- RESP:
  - bready_a = 1.
  - On bvalid_a: err[owner] <= bresp_a, done[owner] pulses for that cycle, last_grant <= owner, go to IDLE.
- Only one transaction is outstanding. Minimum transaction length is 4 cycles for 1 beat (IDLE, ADDR, DATA, RESP) with zero-wait slaves.
- Requesters re-sample in IDLE; a req held after done is eligible on the next IDLE cycle, subject to round-robin.
- Dropping req mid-transaction is ignored; the transaction completes and next/done still pulse.
- Non-owner next/done stay 0. err of the non-owner holds its value.
- reset mid-transaction abandons the burst immediately, with no wlast and no done. The AXI slave side is expected to be reset together.
- valid signals never drop before their handshake.

Optional Feature:
- Macro: GX_WB_ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entry to RESP and increments each RESP cycle without bvalid_a.
  - When it reaches TIMEOUT-1: err[owner] <= 2'b11, done[owner] pulses, bready_a drops, state goes to IDLE.
  - A late bvalid_a arriving in IDLE is ignored.
- Without the macro: RESP waits indefinitely and no counter logic exists.

Decomposition:
- Package gx_wb_pkg holds:
  - The state enum {IDLE, ADDR, DATA, RESP}.
  - AXI constants: SIZE_16B = 3'b100, BURST_INCR = 2'b01.
  - BRESP codes: OKAY = 0, SLVERR = 2, DECERR = 3, with 3 also reused for timeout.
- Sub-module gx_wb_rr_pick: combinational 2-way round-robin picker. Inputs req[1:0] and last_grant; outputs grant and any.

Test Plan:
- req0 alone, size0 = 0, addr0 = 0x1000, zero-wait slave -> one AW with awaddr_a = 0x1000, awlen_a = 0; one W beat with wlast_a = 1; next0 and done0 each pulse once; err0 = 0.
- req0 and req1 asserted together and held -> grant order 0, 1, 0, 1; done pulses alternate; no overlap between transactions.
- req1 with size1 = 1 and wready_a low for 3 cycles on beat 0 -> awlen_a = 1; wlast_a only on the second beat; next1 pulses exactly twice; wdata_a stable while stalled.
- awready_a held low for 5 cycles -> awvalid_a held with a stable awaddr_a; no wvalid_a until the AW handshake.
- bresp_a = 2 on req0's transaction -> err0 = 2 after done0; err1 unchanged. The next OKAY transaction on req0 -> err0 = 0.
- With GX_WB_ARB_TIMEOUT_EN and TIMEOUT = 16, bvalid_a never asserted -> done0 pulses after 16 RESP cycles, err0 = 3, state returns to IDLE. A separate run asserts reset in DATA -> next cycle all outputs are at reset values.
